video_timing_ctrl: RTL and testbench



---
 rtl/video_timing_pkg.sv | 32 +++
 rtl/video_timing_ctrl_if.sv | 51 +++++
 rtl/video_timing_ctrl_sig_delay.sv | 27 ++
 rtl/video_timing_ctrl.sv | 162 ++++++++++++++++
 tb/tb_video_timing_ctrl.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_timing_pkg.sv
// Shared types and constants for the video timing controller: FSM states,
// counter widths and standard raster presets.
package video_timing_pkg;

  localparam int H_CNT_W = 12;
  localparam int V_CNT_W = 11;
  localparam int RGB_W   = 24;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // One axis of a raster, in pixels (horizontal) or lines (vertical).
  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } timing_t;

  localparam timing_t H_640X480 = '{640, 16, 96, 48};
  localparam timing_t V_640X480 = '{480, 10, 2, 33};
  localparam bit      HS_POL_640X480 = 1'b0;
  localparam bit      VS_POL_640X480 = 1'b0;

  localparam timing_t H_800X600 = '{800, 40, 128, 88};
  localparam timing_t V_800X600 = '{600, 1, 4, 23};
  localparam bit      HS_POL_800X600 = 1'b1;
  localparam bit      VS_POL_800X600 = 1'b1;

endpackage

// File: rtl/video_timing_ctrl_if.sv
// Frame-source fetch and TMDS-lane drive signals of the video timing controller.
interface video_timing_ctrl_if;
  import video_timing_pkg::*;

  logic                enable;
  logic                pix_req;
  logic [H_CNT_W-1:0]  pix_x;
  logic [V_CNT_W-1:0]  pix_y;
  logic [RGB_W-1:0]    rgb_in;
  logic [7:0]          red_out;
  logic [7:0]          green_out;
  logic [7:0]          blue_out;
  logic                data_en;
  logic                hsync;
  logic                vsync;
  logic                frame_start;
  logic                running;

  modport master (
    input  enable,
    input  rgb_in,
    output pix_req,
    output pix_x,
    output pix_y,
    output red_out,
    output green_out,
    output blue_out,
    output data_en,
    output hsync,
    output vsync,
    output frame_start,
    output running
  );

  modport slave (
    output enable,
    output rgb_in,
    input  pix_req,
    input  pix_x,
    input  pix_y,
    input  red_out,
    input  green_out,
    input  blue_out,
    input  data_en,
    input  hsync,
    input  vsync,
    input  frame_start,
    input  running
  );

endinterface

// File: rtl/video_timing_ctrl_sig_delay.sv
// Fixed-depth shift register with a synchronous active-low reset value;
// used to line the raster flags up with pixels returning from the source.
module sig_delay #(
  parameter int                 DEPTH   = 2,
  parameter int                 WIDTH   = 3,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sr [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_sr[i] <= RST_VAL;
    end else begin
      r_sr[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/video_timing_ctrl.sv
// Raster sequencer: H/V counters, pixel-fetch requests and TMDS lane drive
// with data, data enable and syncs aligned to the returned pixels.
module video_timing_ctrl
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_640X480.active,
  parameter int H_FP     = H_640X480.fp,
  parameter int H_SYNC   = H_640X480.sync,
  parameter int H_BP     = H_640X480.bp,
  parameter int V_ACTIVE = V_640X480.active,
  parameter int V_FP     = V_640X480.fp,
  parameter int V_SYNC   = V_640X480.sync,
  parameter int V_BP     = V_640X480.bp,
  parameter bit HS_POL   = HS_POL_640X480,
  parameter bit VS_POL   = VS_POL_640X480,
  parameter int PIX_LAT  = 2
) (
  input  logic                clk,
  input  logic                rst,
  video_timing_ctrl_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // One extra bit so sync-end bounds equal to 4096/2048 still compare correctly.
  localparam int HX_W = H_CNT_W + 1;
  localparam int VX_W = V_CNT_W + 1;

  localparam logic [HX_W-1:0] H_ACT_C  = HX_W'(H_ACTIVE);
  localparam logic [HX_W-1:0] HS_BEG_C = HX_W'(H_ACTIVE + H_FP);
  localparam logic [HX_W-1:0] HS_END_C = HX_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HX_W-1:0] H_LAST_C = HX_W'(H_TOTAL - 1);
  localparam logic [VX_W-1:0] V_ACT_C  = VX_W'(V_ACTIVE);
  localparam logic [VX_W-1:0] VS_BEG_C = VX_W'(V_ACTIVE + V_FP);
  localparam logic [VX_W-1:0] VS_END_C = VX_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VX_W-1:0] V_LAST_C = VX_W'(V_TOTAL - 1);

  state_t               r_state;
  logic [H_CNT_W-1:0]   r_h_cnt;
  logic [V_CNT_W-1:0]   r_v_cnt;

  logic                 r_pix_req;
  logic [H_CNT_W-1:0]   r_pix_x;
  logic [V_CNT_W-1:0]   r_pix_y;
  logic                 r_hs0;
  logic                 r_vs0;
  logic                 r_frame_start;
  logic                 r_running;

  logic                 r_de;
  logic                 r_hsync;
  logic                 r_vsync;
  logic [RGB_W-1:0]     r_rgb;

  logic [HX_W-1:0]      w_h;
  logic [VX_W-1:0]      w_v;
  logic                 w_run;
  logic                 w_eol;
  logic                 w_eof;
  logic                 w_act;
  logic                 w_hs0;
  logic                 w_vs0;
  logic                 w_org;
  logic [2:0]           w_dly;

  assign w_h   = {1'b0, r_h_cnt};
  assign w_v   = {1'b0, r_v_cnt};
  assign w_run = (r_state == ST_RUN);
  assign w_eol = (w_h == H_LAST_C);
  assign w_eof = w_eol && (w_v == V_LAST_C);
  assign w_act = w_run && (w_h < H_ACT_C) && (w_v < V_ACT_C);
  assign w_hs0 = w_run && (w_h >= HS_BEG_C) && (w_h < HS_END_C);
  assign w_vs0 = w_run && (w_v >= VS_BEG_C) && (w_v < VS_END_C);
  assign w_org = w_run && (r_h_cnt == '0) && (r_v_cnt == '0);

  // Stage 0: FSM, raster counters and decoded fetch/sync flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_pix_req     <= 1'b0;
      r_pix_x       <= '0;
      r_pix_y       <= '0;
      r_hs0         <= 1'b0;
      r_vs0         <= 1'b0;
      r_frame_start <= 1'b0;
      r_running     <= 1'b0;
    end else begin
      r_pix_req     <= w_act;
      r_pix_x       <= r_h_cnt;
      r_pix_y       <= r_v_cnt;
      r_hs0         <= w_hs0;
      r_vs0         <= w_vs0;
      r_frame_start <= w_org;
      r_running     <= w_run;
      case (r_state)
        ST_IDLE: begin
          r_h_cnt <= '0;
          r_v_cnt <= '0;
          if (bus.enable) r_state <= ST_RUN;
        end
        ST_RUN: begin
          // enable is only looked at on the last pixel, so frames are never cut short.
          if (!w_eol) begin
            r_h_cnt <= r_h_cnt + 1'b1;
          end else begin
            r_h_cnt <= '0;
            if (!w_eof) begin
              r_v_cnt <= r_v_cnt + 1'b1;
            end else begin
              r_v_cnt <= '0;
              if (!bus.enable) r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Stage 1..PIX_LAT: flags wait for the frame source round trip.
  sig_delay #(
    .DEPTH   (PIX_LAT),
    .WIDTH   (3),
    .RST_VAL (3'b000)
  ) u_flag_dly (
    .clk (clk),
    .rst (rst),
    .i_d ({r_pix_req, r_hs0, r_vs0}),
    .o_q (w_dly)
  );

  // Output stage: pixel capture and polarity-adjusted syncs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_de    <= 1'b0;
      r_hsync <= ~HS_POL;
      r_vsync <= ~VS_POL;
      r_rgb   <= '0;
    end else begin
      r_de    <= w_dly[2];
      r_hsync <= w_dly[1] ? HS_POL : ~HS_POL;
      r_vsync <= w_dly[0] ? VS_POL : ~VS_POL;
      r_rgb   <= w_dly[2] ? bus.rgb_in : '0;
    end
  end

  assign bus.pix_req     = r_pix_req;
  assign bus.pix_x       = r_pix_x;
  assign bus.pix_y       = r_pix_y;
  assign bus.frame_start = r_frame_start;
  assign bus.running     = r_running;
  assign bus.data_en     = r_de;
  assign bus.hsync       = r_hsync;
  assign bus.vsync       = r_vsync;
  assign bus.red_out     = r_rgb[23:16];
  assign bus.green_out   = r_rgb[15:8];
  assign bus.blue_out    = r_rgb[7:0];

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Bench for video_timing_ctrl: a VGA instance and two tiny rasters at pixel
// latencies 1 and 8, compared every cycle against a frame-position model.
`timescale 1ns/1ps
module tb_video_timing_ctrl;
  import video_timing_pkg::*;

  localparam int NI   = 3;
  localparam int RING = 16;

  typedef struct packed {
    logic               req;
    logic               hs;
    logic               vs;
    logic [H_CNT_W-1:0] x;
    logic [V_CNT_W-1:0] y;
  } s0_t;

  typedef struct packed {
    logic               req;
    logic [H_CNT_W-1:0] x;
    logic [V_CNT_W-1:0] y;
    logic [23:0]        rgb;
    logic               de;
    logic               hs;
    logic               vs;
    logic               fs;
    logic               run;
  } obs_t;

  int cfg_ha  [NI] = '{640, 8, 8};
  int cfg_hf  [NI] = '{16, 2, 2};
  int cfg_hs  [NI] = '{96, 3, 3};
  int cfg_hb  [NI] = '{48, 2, 2};
  int cfg_va  [NI] = '{480, 4, 4};
  int cfg_vf  [NI] = '{10, 1, 1};
  int cfg_vs  [NI] = '{2, 1, 1};
  int cfg_vb  [NI] = '{33, 1, 1};
  int cfg_lat [NI] = '{2, 1, 8};

  logic clk    = 1'b0;
  logic rst    = 1'b0;
  logic enable = 1'b0;

  always #5 clk = ~clk;

  video_timing_ctrl_if bus0 ();
  video_timing_ctrl_if bus1 ();
  video_timing_ctrl_if bus2 ();

  assign bus0.enable = enable;
  assign bus1.enable = enable;
  assign bus2.enable = enable;

  video_timing_ctrl #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIX_LAT(2)
  ) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

  video_timing_ctrl #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIX_LAT(1)
  ) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  video_timing_ctrl #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIX_LAT(8)
  ) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   m_valid = 1'b0;
  bit   m_run [NI];
  int   m_t [NI];
  int   since [NI];
  s0_t  ring [NI][RING];
  logic [H_CNT_W+V_CNT_W-1:0] src [NI][RING];
  obs_t obs [NI];
  obs_t exp_o [NI];

  bit   meas = 1'b0;
  int   last_fs [NI];
  int   req_cnt [NI];
  int   fs_cnt [NI];
  int   hs_run = 0;
  int   line0_req = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: a frame is a linear run of H_TOTAL*V_TOTAL pixel slots.
  task automatic model_step(input logic rs, input logic en);
    for (int i = 0; i < NI; i++) begin
      int   ht, vt, h, v;
      s0_t  s, e;
      logic fs, run;
      ht  = cfg_ha[i] + cfg_hf[i] + cfg_hs[i] + cfg_hb[i];
      vt  = cfg_va[i] + cfg_vf[i] + cfg_vs[i] + cfg_vb[i];
      s   = '0;
      fs  = 1'b0;
      run = 1'b0;
      if (!rs) begin
        m_run[i] = 1'b0;
        m_t[i]   = 0;
        since[i] = 0;
      end else begin
        h = m_t[i] % ht;
        v = m_t[i] / ht;
        s.req = m_run[i] && (h < cfg_ha[i]) && (v < cfg_va[i]);
        s.hs  = m_run[i] && (h >= cfg_ha[i] + cfg_hf[i]) && (h < cfg_ha[i] + cfg_hf[i] + cfg_hs[i]);
        s.vs  = m_run[i] && (v >= cfg_va[i] + cfg_vf[i]) && (v < cfg_va[i] + cfg_vf[i] + cfg_vs[i]);
        s.x   = H_CNT_W'(h);
        s.y   = V_CNT_W'(v);
        fs    = m_run[i] && (m_t[i] == 0);
        run   = m_run[i];
        if (!m_run[i]) begin
          if (en) begin
            m_run[i] = 1'b1;
            m_t[i]   = 0;
          end
        end else if (m_t[i] == ht * vt - 1) begin
          m_t[i] = 0;
          if (!en) m_run[i] = 1'b0;
        end else begin
          m_t[i]++;
        end
        since[i]++;
      end
      ring[i][cyc % RING] = s;
      if (rs && since[i] >= cfg_lat[i] + 1) e = ring[i][(cyc + RING - cfg_lat[i] - 1) % RING];
      else e = '0;
      exp_o[i] = {s.req, s.x, s.y,
                  (e.req ? {e.x[7:0], e.y[7:0], 8'hA5} : 24'h0),
                  e.req, ~e.hs, ~e.vs, fs, run};
    end
    if (!rs) m_valid = 1'b1;
  endtask

  function automatic logic [23:0] src_rgb(input int i);
    logic [H_CNT_W+V_CNT_W-1:0] p;
    p = src[i][(cyc + RING - cfg_lat[i]) % RING];
    return {p[V_CNT_W+7:V_CNT_W], p[7:0], 8'hA5};
  endfunction

  task automatic observe();
    obs[0] = {bus0.pix_req, bus0.pix_x, bus0.pix_y, bus0.red_out, bus0.green_out, bus0.blue_out,
              bus0.data_en, bus0.hsync, bus0.vsync, bus0.frame_start, bus0.running};
    obs[1] = {bus1.pix_req, bus1.pix_x, bus1.pix_y, bus1.red_out, bus1.green_out, bus1.blue_out,
              bus1.data_en, bus1.hsync, bus1.vsync, bus1.frame_start, bus1.running};
    obs[2] = {bus2.pix_req, bus2.pix_x, bus2.pix_y, bus2.red_out, bus2.green_out, bus2.blue_out,
              bus2.data_en, bus2.hsync, bus2.vsync, bus2.frame_start, bus2.running};
    for (int i = 0; i < NI; i++) begin
      if (m_valid) chk_eq($sformatf("inst%0d_out@%0d", i, cyc), 64'(obs[i]), 64'(exp_o[i]));
      src[i][cyc % RING] = {obs[i].x, obs[i].y};
      if (obs[i].fs) fs_cnt[i]++;
      if (meas && i > 0) begin
        if (obs[i].fs) begin
          if (last_fs[i] >= 0) begin
            chk_eq($sformatf("inst%0d_frame_period", i), 64'(cyc - last_fs[i]),
                   64'((cfg_ha[i] + cfg_hf[i] + cfg_hs[i] + cfg_hb[i]) *
                       (cfg_va[i] + cfg_vf[i] + cfg_vs[i] + cfg_vb[i])));
            chk_eq($sformatf("inst%0d_req_per_frame", i), 64'(req_cnt[i]),
                   64'(cfg_ha[i] * cfg_va[i]));
          end
          last_fs[i] = cyc;
          req_cnt[i] = 0;
        end
        if (obs[i].req) req_cnt[i]++;
      end
    end
    if (meas) begin
      if (!obs[0].hs) hs_run++;
      else if (hs_run > 0) begin
        chk_eq("inst0_hsync_width", 64'(hs_run), 64'(cfg_hs[0]));
        hs_run = 0;
      end
      if (obs[0].req && obs[0].y == '0) line0_req++;
    end
    bus0.rgb_in = src_rgb(0);
    bus1.rgb_in = src_rgb(1);
    bus2.rgb_in = src_rgb(2);
  endtask

  task automatic tick();
    logic rs, en;
    rs = rst;
    en = enable;
    @(posedge clk);
    model_step(rs, en);
    #1;
    observe();
    cyc++;
  endtask

  initial begin
    bus0.rgb_in = '0;
    bus1.rgb_in = '0;
    bus2.rgb_in = '0;
    for (int i = 0; i < NI; i++) begin
      last_fs[i] = -1;
      req_cnt[i] = 0;
      fs_cnt[i]  = 0;
    end

    rst = 1'b0;
    enable = 1'b0;
    repeat (3) tick();

    // Continuous run from reset.
    rst = 1'b1;
    enable = 1'b1;
    meas = 1'b1;
    repeat (2000) tick();
    meas = 1'b0;
    chk_eq("inst0_line0_requests", 64'(line0_req), 64'(cfg_ha[0]));

    // Random enable toggling.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 24) == 0) enable = ~enable;
      tick();
    end

    // Let the short rasters finish, then a one-cycle enable pulse.
    enable = 1'b0;
    repeat (120) tick();
    fs_cnt[1] = 0;
    fs_cnt[2] = 0;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    repeat (300) tick();
    chk_eq("inst1_pulse_frames", 64'(fs_cnt[1]), 64'd1);
    chk_eq("inst2_pulse_frames", 64'(fs_cnt[2]), 64'd1);

    // Enable dropped mid-frame, then reset mid-frame and restart.
    enable = 1'b1;
    repeat (30) tick();
    enable = 1'b0;
    repeat (150) tick();
    enable = 1'b1;
    repeat (47) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    repeat (60) tick();

    // Random resets mixed with random enable.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 29) == 0) enable = ~enable;
      rst = ($urandom_range(0, 149) != 0);
      tick();
    end

    rst = 1'b1;
    enable = 1'b0;
    repeat (200) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
